// File: rtl/clk_period_monitor.sv
// Measures period and high time of an asynchronous divided clock in clock_in cycles,
// flags a stalled input; optional lock detection under CLK_PERIOD_MONITOR_LOCK_EN.
module clk_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             stuck,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t           state_reg, state_next;
  logic             s1_reg, s2_reg, s3_reg;
  logic             rise;
  logic             timeout_hit;
  logic             arm, publish, expire;
  logic [CNT_W-1:0] per_cnt_reg, hi_cnt_reg;
  logic [CNT_W-1:0] period_reg, high_reg;
  logic             meas_valid_reg, stuck_reg;

  // Two-flop synchroniser plus one flop for rising-edge detection
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= sig_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise        = s2_reg & ~s3_reg;
  assign timeout_hit = (per_cnt_reg >= TIMEOUT_C);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = ARMED;
      ARMED:   if (!rise && timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rise always beats a coincident timeout
  always_comb begin
    arm     = 1'b0;
    publish = 1'b0;
    expire  = 1'b0;
    case (state_reg)
      IDLE:  arm = rise;
      ARMED: begin
        publish = rise;
        expire  = !rise && timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end else if (arm || publish) begin
      per_cnt_reg <= CNT_ONE;
      hi_cnt_reg  <= CNT_ONE;
    end else if (state_reg == ARMED && !expire) begin
      if (per_cnt_reg != CNT_MAX) per_cnt_reg <= per_cnt_reg + CNT_ONE;
      if (s2_reg && hi_cnt_reg != CNT_MAX) hi_cnt_reg <= hi_cnt_reg + CNT_ONE;
    end else begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      period_reg     <= '0;
      high_reg       <= '0;
      meas_valid_reg <= 1'b0;
      stuck_reg      <= 1'b0;
    end else begin
      meas_valid_reg <= publish;
      if (publish) begin
        period_reg <= per_cnt_reg;
        high_reg   <= hi_cnt_reg;
      end
      if (expire)   stuck_reg <= 1'b1;
      else if (arm) stuck_reg <= 1'b0;
    end
  end

  assign period_out = period_reg;
  assign high_out   = high_reg;
  assign meas_valid = meas_valid_reg;
  assign stuck      = stuck_reg;

`ifdef CLK_PERIOD_MONITOR_LOCK_EN
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [LW-1:0] LOCK_C = LW'(LOCK_COUNT);

  logic [LW-1:0] match_cnt_reg;

  // New pair is compared against the previously published pair still held in the outputs
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt_reg <= '0;
    end else if (expire) begin
      match_cnt_reg <= '0;
    end else if (publish) begin
      if (per_cnt_reg == period_reg && hi_cnt_reg == high_reg) begin
        if (match_cnt_reg != LOCK_C) match_cnt_reg <= match_cnt_reg + LW'(1);
      end else begin
        match_cnt_reg <= LW'(1);
      end
    end
  end

  assign locked = (match_cnt_reg == LOCK_C);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: a cycle model pushes expected
// measurements per driven rising edge; a monitor pops them on meas_valid.
module tb_clk_period_monitor;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 64;
  localparam int LOCK_COUNT = 4;

  logic             clock_in = 1'b0;
  logic             reset_n;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             stuck;
  logic             locked;

  clk_period_monitor #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .stuck     (stuck),
    .locked    (locked)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
    logic             l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Input-side model of the measurement, aligned to the driven sig_in cycles
  bit prev_sig, armed_m, stuck_m;
  int cnt_m, hi_m, match_m, last_p, last_h;

  task automatic model_reset();
    prev_sig = 0; armed_m = 0; stuck_m = 0;
    cnt_m = 0; hi_m = 0; match_m = 0; last_p = 0; last_h = 0;
    q.delete();
  endtask

  task automatic push_expected(input int p, input int h);
    exp_t e;
    if (p == last_p && h == last_h) match_m = (match_m < LOCK_COUNT) ? match_m + 1 : LOCK_COUNT;
    else                            match_m = 1;
    last_p = p;
    last_h = h;
    e.p = CNT_W'(p);
    e.h = CNT_W'(h);
`ifdef CLK_PERIOD_MONITOR_LOCK_EN
    e.l = (match_m == LOCK_COUNT);
`else
    e.l = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic drive_cycle(input bit v);
    @(posedge clock_in);
    #1 sig_in = v;
    if (v && !prev_sig) begin
      if (armed_m) push_expected(cnt_m, hi_m);
      armed_m = 1; stuck_m = 0; cnt_m = 1; hi_m = 1;
    end else if (armed_m) begin
      if (cnt_m >= TIMEOUT) begin
        armed_m = 0; stuck_m = 1; match_m = 0; cnt_m = 0; hi_m = 0;
      end else begin
        cnt_m++;
        if (v) hi_m++;
      end
    end
    prev_sig = v;
  endtask

  task automatic drive_period(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) drive_cycle(c < h);
    end
  endtask

  task automatic flush();
    repeat (5) drive_cycle(prev_sig);
  endtask

  always @(negedge clock_in) begin
    if (reset_n === 1'b1 && meas_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_meas_valid period=%0d high=%0d", period_out, high_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (period_out !== e.p || high_out !== e.h || locked !== e.l) begin
          errors++;
          $display("FAIL meas got period=%0d high=%0d locked=%0b expected period=%0d high=%0d locked=%0b",
                   period_out, high_out, locked, e.p, e.h, e.l);
        end else begin
          $display("meas period=%0d high=%0d locked=%0b", period_out, high_out, locked);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    sig_in  = 1'b0;
    model_reset();
    repeat (3) @(posedge clock_in);
    #2;
    checks++;
    if ({period_out, high_out, meas_valid, stuck, locked} !== '0) begin
      errors++;
      $display("FAIL reset_state got p=%0d h=%0d mv=%0b st=%0b lk=%0b expected all 0",
               period_out, high_out, meas_valid, stuck, locked);
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (3) drive_cycle(1'b0);
    checks++;
    if ({period_out, high_out, meas_valid, stuck} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got p=%0d h=%0d mv=%0b st=%0b expected all 0",
               period_out, high_out, meas_valid, stuck);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d unpublished expected 0", name, q.size());
    end
  endtask

  task automatic test_div2();
    drive_period(2, 1, 12);
    flush();
    check_drained("div2");
  endtask

  task automatic test_div3();
    drive_period(3, 1, 6);
    drive_period(3, 2, 6);
    flush();
    check_drained("div3");
  endtask

  task automatic test_stall();
    drive_period(8, 4, 4);
    repeat (20) drive_cycle(1'b0);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stall_early got stuck=%0b expected 0", stuck);
    end
    repeat (60) drive_cycle(1'b0);
    checks++;
    if (stuck !== stuck_m || stuck_m != 1) begin
      errors++;
      $display("FAIL stall_stuck got stuck=%0b expected 1", stuck);
    end
    repeat (4) drive_cycle(1'b1);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clear got stuck=%0b expected 0", stuck);
    end
    repeat (4) drive_cycle(1'b0);
    drive_period(8, 4, 2);
    flush();
    check_drained("stall");
  endtask

  task automatic test_lock();
    drive_period(6, 3, 6);
    drive_period(7, 3, 1);
    drive_period(7, 3, 5);
    flush();
    check_drained("lock");
    checks++;
`ifdef CLK_PERIOD_MONITOR_LOCK_EN
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_final got locked=%0b expected 1", locked);
    end
`else
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_final got locked=%0b expected 0", locked);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive_period(10, 5, 3);
    repeat (5) drive_cycle(1'b1);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({period_out, high_out, meas_valid, stuck, locked} !== '0) begin
      errors++;
      $display("FAIL reset_mid got p=%0d h=%0d mv=%0b st=%0b lk=%0b expected all 0",
               period_out, high_out, meas_valid, stuck, locked);
    end
    check_drained("pre_reset");
    sig_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    reset_n = 1'b1;
    drive_period(10, 5, 3);
    flush();
    check_drained("reset_mid");
    checks++;
    if (period_out !== CNT_W'(10)) begin
      errors++;
      $display("FAIL reset_mid_period got %0d expected 10", period_out);
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div3();
    test_stall();
    test_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
